dmem_timer_responder: RTL and testbench
=======================================

// Module: dmem_timer_responder
// PURPOSE
//  Memory-mapped interval timer that responds to the PMIPSL0 data-memory bus
//  (dmemaddr/dmemwdata/dmemwrite/dmemread). It sits beside DMemory_IO as a second bus slave.
//  The CPU programs a reload value and control bits, then reads the live count or
//  polls/clears an expiry flag. irq is exported for a later interrupt controller.
// PARAMETERS
//  BASE      16'hFF00  byte address of register block; BASE[2:0] must be 0
//  PRESCALE  4         clock cycles per count decrement, >=1
// PORTS
//  clock      in   1   system clock, all state updates on rising edge
//  reset      in   1   asynchronous, active-low; 0 clears all state immediately
//  dmemaddr   in   16  data-memory byte address from CPU
//  dmemwdata  in   16  data-memory write data from CPU
//  dmemwrite  in   1   write enable; sampled on rising clock
//  dmemread   in   1   read enable
//  rdata      out  16  read data, combinational; 16'h0000 when not selected
//  sel        out  1   1 when dmemaddr[15:3]==BASE[15:3]; external read-data mux select
//  irq        out  1   expired & CTRL.ie
// BEHAVIOUR
//  Decode: hit = (dmemaddr[15:3]==BASE[15:3]); register = dmemaddr[2:1]; dmemaddr[0] ignored.
//   00 CTRL   [0]en [1]auto_reload [2]ie, others read 0; R/W
//   01 RELOAD 16-bit; R/W; a write also loads COUNT and clears prescaler
//   10 COUNT  16-bit; read-only, writes ignored
//   11 STATUS [0]expired; write 1 to bit0 clears it, write 0 no effect
//  Reads: rdata = selected register when hit & dmemread, else 0. No wait states, zero latency.
//  Writes take effect at the rising edge where hit & dmemwrite; read-back next cycle.
//  Reset (reset==0): CTRL=0, RELOAD=0, COUNT=0, prescaler=0, expired=0; rdata=0, irq=0.
//  Prescaler: counts 0..PRESCALE-1 while en=1; tick when it equals PRESCALE-1, then wraps to 0.
//   en=0 holds prescaler at 0 and freezes COUNT.
//  Count FSM, implicit in en/COUNT:
//   IDLE  (en=0): nothing changes.
//   RUN   (en=1, COUNT>0): on tick, COUNT<=COUNT-1.
//   EXPIRE (en=1, COUNT==0 at tick): expired<=1;
//     auto_reload=1 -> COUNT<=RELOAD, stay RUN;
//     auto_reload=0 -> en<=0 (one-shot), COUNT stays 0.
//  RELOAD=0 with auto_reload=1: expires on every tick.
//  Enabling with COUNT==0: expiry occurs at the first tick (PRESCALE cycles).
//  Same edge: hardware expiry and STATUS clear write -> set wins, expired=1.
//  Same edge: RELOAD write and tick -> write wins; COUNT=new value, prescaler=0, no decrement.
//  Same edge: CTRL write and one-shot auto-clear of en -> CTRL write wins.
//  COUNT never wraps below 0; all arithmetic is unsigned 16-bit.
//  reset asserted mid-count: immediate return to reset values, no expiry recorded.
//  dmemwrite and dmemread together: read returns the pre-write value; write lands at the edge.
// TESTING
//  1 Reset: hold reset=0, toggle clock and bus -> rdata=0, irq=0; all four registers read 0 after release.
//  2 One-shot: write RELOAD=3, CTRL=16'h0005 -> COUNT reads 3,2,1,0 at 4-cycle steps;
//    expired=1 and irq=1 at cycle 16; CTRL.en reads 0; COUNT stays 0.
//  3 Auto-reload: RELOAD=2, CTRL=16'h0003 -> expired sets at cycle 12; COUNT reloads to 2;
//    write STATUS=1 clears it; it sets again 12 cycles later.
//  4 Clear/expire collision: schedule a STATUS=1 write on the expiry edge -> expired stays 1.
//  5 Decode: write to 16'hFF08 and 16'hFEF8 -> no register change, sel=0, rdata=0;
//    read 16'hFF05 -> returns COUNT (bit0 ignored).
//  6 Async reset mid-run: assert reset between clock edges with COUNT=5 -> COUNT, CTRL and
//    expired are 0 before the next edge.

Source files
------------

// File: rtl/dmem_timer_responder.sv
// Memory-mapped interval timer, second slave on the data-memory bus.
// Registers (byte offsets from BASE): 0 CTRL, 2 RELOAD, 4 COUNT, 6 STATUS.
module dmem_timer_responder #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] rdata,
  output logic        sel,
  output logic        irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    R_CTRL   = 2'b00,
    R_RELOAD = 2'b01,
    R_COUNT  = 2'b10,
    R_STATUS = 2'b11
  } reg_e;

  // ctrl_q: [0] en, [1] auto_reload, [2] ie
  logic [2:0]    ctrl_q, ctrl_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          expired_q, expired_d;

  logic hit, wr_ctrl, wr_reload, wr_status, tick, expire;
  reg_e rsel;

  // Byte-lane bit of the address carries no meaning for 16-bit registers.
  logic unused_addr0;
  assign unused_addr0 = dmemaddr[0];

  assign hit  = (dmemaddr[15:3] == BASE[15:3]);
  assign rsel = reg_e'(dmemaddr[2:1]);
  assign sel  = hit;

  assign wr_ctrl   = hit && dmemwrite && (rsel == R_CTRL);
  assign wr_reload = hit && dmemwrite && (rsel == R_RELOAD);
  assign wr_status = hit && dmemwrite && (rsel == R_STATUS);

  // A RELOAD write on a tick edge fully pre-empts the tick (no decrement, no expiry).
  assign tick   = ctrl_q[0] && (pre_q == PRE_MAX) && !wr_reload;
  assign expire = tick && (count_q == 16'h0000);

  // Combinational read mux; zero when not addressed so it can be OR-ed externally.
  always_comb begin
    rdata = 16'h0000;
    if (hit && dmemread) begin
      case (rsel)
        R_CTRL:   rdata = {13'h0000, ctrl_q};
        R_RELOAD: rdata = reload_q;
        R_COUNT:  rdata = count_q;
        R_STATUS: rdata = {15'h0000, expired_q};
        default:  rdata = 16'h0000;
      endcase
    end
  end

  assign irq = expired_q & ctrl_q[2];

  // Next-state: prescaler, count FSM, bus writes with their edge priorities.
  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    pre_d     = pre_q;
    expired_d = expired_q;

    // Prescaler free-runs only while enabled.
    if (!ctrl_q[0] || tick) pre_d = '0;
    else                    pre_d = pre_q + PW'(1);

    // Count FSM: decrement while running, reload or one-shot stop on expiry.
    if (tick) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'h0001;
      end else if (ctrl_q[1]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end

    // Status clear loses to a simultaneous hardware set.
    if (wr_status && dmemwdata[0]) expired_d = 1'b0;
    if (expire)                    expired_d = 1'b1;

    // Bus writes override hardware updates of the same register.
    if (wr_ctrl) ctrl_d = dmemwdata[2:0];
    if (wr_reload) begin
      reload_d = dmemwdata;
      count_d  = dmemwdata;
      pre_d    = '0;
    end
  end

  // State registers, cleared immediately by the async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Directed bench for dmem_timer_responder: vector table plus timed sequences.
module tb_dmem_timer_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] dmemaddr = 16'h0000;
  logic [15:0] dmemwdata = 16'h0000;
  logic        dmemwrite = 1'b0;
  logic        dmemread = 1'b0;
  logic [15:0] rdata;
  logic        sel;
  logic        irq;

  int total = 0;
  int bad   = 0;

  dmem_timer_responder #(.BASE(16'hFF00), .PRESCALE(4)) dut (
    .clock(clock), .reset(reset), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
    .dmemwrite(dmemwrite), .dmemread(dmemread), .rdata(rdata), .sel(sel), .irq(irq)
  );

  always #5 clock = ~clock;

  localparam logic [15:0] A_CTRL = 16'hFF00, A_RELOAD = 16'hFF02,
                          A_COUNT = 16'hFF04, A_STATUS = 16'hFF06;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] exp_rdata;
    logic        exp_sel;
    logic        exp_irq;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue a single-cycle bus write that lands on the next rising edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    dmemaddr  = a;
    dmemwdata = d;
    dmemwrite = 1'b1;
    @(negedge clock);
    dmemwrite = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    dmemaddr = a;
    dmemread = 1'b1;
    #1;
    v = rdata;
    dmemread = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  vec_t vecs[16];
  logic [15:0] v;

  initial begin
    // addr, wdata, we, re, exp_rdata, exp_sel, exp_irq
    vecs[0]  = '{A_RELOAD, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{A_RELOAD, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[2]  = '{A_COUNT,  16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[3]  = '{A_COUNT,  16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{16'hFF05, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[5]  = '{A_CTRL,   16'hFFF6, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{A_CTRL,   16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0};
    vecs[7]  = '{A_RELOAD, 16'h0042, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[8]  = '{A_RELOAD, 16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0};
    vecs[9]  = '{16'hFF08, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{16'hFEF8, 16'h0001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'hFF08, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{A_COUNT,  16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0};
    vecs[13] = '{A_CTRL,   16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0};
    vecs[14] = '{A_CTRL,   16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{A_STATUS, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    // ---- Reset held while bus is active ----
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      dmemaddr = A_RELOAD; dmemwdata = 16'hABCD; dmemwrite = 1'b1; dmemread = 1'b1;
      #1;
      chk("rst_rdata", rdata, 16'h0000);
      chk("rst_irq", {15'h0, irq}, 16'h0000);
    end
    @(negedge clock);
    dmemwrite = 1'b0; dmemread = 1'b0;
    reset = 1'b1;
    rd(A_CTRL, v);   chk("rst_ctrl", v, 16'h0000);
    rd(A_RELOAD, v); chk("rst_reload", v, 16'h0000);
    rd(A_COUNT, v);  chk("rst_count", v, 16'h0000);
    rd(A_STATUS, v); chk("rst_status", v, 16'h0000);

    // ---- Register/decode vector table (timer stays disabled) ----
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      dmemaddr = vecs[i].addr; dmemwdata = vecs[i].wdata;
      dmemwrite = vecs[i].we;  dmemread = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_sel", i), {15'h0, sel}, {15'h0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), {15'h0, irq}, {15'h0, vecs[i].exp_irq});
      @(negedge clock);
      dmemwrite = 1'b0; dmemread = 1'b0;
    end

    // ---- One-shot ----
    do_reset();
    @(negedge clock);
    bus_write(A_RELOAD, 16'd3);
    bus_write(A_CTRL, 16'h0005);
    rd(A_COUNT, v); chk("os_cnt3", v, 16'd3);
    cycles(4); rd(A_COUNT, v); chk("os_cnt2", v, 16'd2);
    cycles(4); rd(A_COUNT, v); chk("os_cnt1", v, 16'd1);
    cycles(4); rd(A_COUNT, v); chk("os_cnt0", v, 16'd0);
    cycles(3); rd(A_STATUS, v); chk("os_not_yet", v, 16'd0);
    chk("os_irq_low", {15'h0, irq}, 16'h0000);
    cycles(1); rd(A_STATUS, v); chk("os_expired", v, 16'd1);
    chk("os_irq", {15'h0, irq}, 16'h0001);
    rd(A_CTRL, v); chk("os_ctrl_en_clr", v, 16'h0004);
    cycles(8); rd(A_COUNT, v); chk("os_cnt_stays0", v, 16'd0);

    // ---- Auto-reload, clear, re-expiry, and clear/expire collision ----
    do_reset();
    @(negedge clock);
    bus_write(A_RELOAD, 16'd2);
    bus_write(A_CTRL, 16'h0003);
    cycles(11); rd(A_STATUS, v); chk("ar_not_yet", v, 16'd0);
    cycles(1);  rd(A_STATUS, v); chk("ar_expired", v, 16'd1);
    rd(A_COUNT, v); chk("ar_reloaded", v, 16'd2);
    chk("ar_irq_masked", {15'h0, irq}, 16'h0000);
    bus_write(A_STATUS, 16'h0001);
    rd(A_STATUS, v); chk("ar_cleared", v, 16'd0);
    cycles(10); rd(A_STATUS, v); chk("ar_not_yet2", v, 16'd0);
    cycles(1);  rd(A_STATUS, v); chk("ar_expired2", v, 16'd1);
    bus_write(A_STATUS, 16'h0000);
    rd(A_STATUS, v); chk("ar_w0_noeffect", v, 16'd1);
    bus_write(A_STATUS, 16'h0001);
    rd(A_STATUS, v); chk("ar_cleared2", v, 16'd0);
    cycles(9);
    rd(A_STATUS, v); chk("col_pre", v, 16'd0);
    bus_write(A_STATUS, 16'h0001);
    rd(A_STATUS, v); chk("col_set_wins", v, 16'd1);
    rd(A_COUNT, v); chk("col_reloaded", v, 16'd2);

    // ---- Async reset mid-run ----
    do_reset();
    @(negedge clock);
    bus_write(A_RELOAD, 16'd0);
    bus_write(A_CTRL, 16'h0001);
    cycles(4);
    bus_write(A_RELOAD, 16'd5);
    bus_write(A_CTRL, 16'h0005);
    cycles(2);
    rd(A_COUNT, v);  chk("ar5_count", v, 16'd5);
    rd(A_STATUS, v); chk("ar5_expired", v, 16'd1);
    chk("ar5_irq", {15'h0, irq}, 16'h0001);
    @(negedge clock);
    #2 reset = 1'b0;
    rd(A_COUNT, v);  chk("async_count", v, 16'd0);
    rd(A_CTRL, v);   chk("async_ctrl", v, 16'd0);
    rd(A_STATUS, v); chk("async_expired", v, 16'd0);
    chk("async_irq", {15'h0, irq}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
